// File: rtl/clkgen_pkg.sv
`default_nettype none
// clkgen_pkg: shared widths, limits, config record and divider state encoding (rev 1.0)
package clkgen_pkg;

  localparam int CLKGEN_INT_W  = 8;
  localparam int CLKGEN_FRAC_W = 8;
  localparam int MIN_INT       = 2;

  typedef struct packed {
    logic [CLKGEN_INT_W-1:0]  m;
    logic [CLKGEN_FRAC_W-1:0] num;
    logic [CLKGEN_FRAC_W-1:0] den;
  } cfg_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_divider_frac_prog_if.sv
`default_nettype none
// clk_divider_frac_prog_if: control/config bundle and divider status outputs (rev 1.0)
interface clk_divider_frac_prog_if
  import clkgen_pkg::*;
#(
  parameter int INT_W  = CLKGEN_INT_W,
  parameter int FRAC_W = CLKGEN_FRAC_W
);

  logic              en;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_num;
  logic [FRAC_W-1:0] cfg_den;
  logic              cfg_load;
  logic              cfg_err;
  logic              clk_div_pulse;
  logic              clk_div;
  logic              period_long;
  logic              active;

  modport master (
    output en, cfg_int, cfg_num, cfg_den, cfg_load,
    input  cfg_err, clk_div_pulse, clk_div, period_long, active
  );

  modport slave (
    input  en, cfg_int, cfg_num, cfg_den, cfg_load,
    output cfg_err, clk_div_pulse, clk_div, period_long, active
  );

endinterface
`default_nettype wire

// File: rtl/frac_err_acc.sv
`default_nettype none
// frac_err_acc: first-order error accumulator deciding long/short periods (rev 1.0)
module frac_err_acc #(
  parameter int FRAC_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  input  wire logic              i_flush,
  input  wire logic              i_step,
  input  wire logic              i_restart,
  input  wire logic [FRAC_W-1:0] i_num,
  input  wire logic [FRAC_W-1:0] i_den,
  output logic                   o_long
);

  // One spare MSB holds the sum; stored residue stays below den so it is always 0
  logic [FRAC_W:0] r_acc;
  logic [FRAC_W:0] w_base;
  logic [FRAC_W:0] w_sum;
  logic [FRAC_W:0] w_acc_nx;

  assign w_base   = i_restart ? '0 : r_acc;
  assign w_sum    = w_base + {1'b0, i_num};
  assign o_long   = (w_sum >= {1'b0, i_den});
  assign w_acc_nx = o_long ? (w_sum - {1'b0, i_den}) : w_sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_divider_frac_prog.sv
`default_nettype none
// clk_divider_frac_prog: programmable M+NUM/DEN dual-modulus clock divider with
// registered strobe, near-50% divided clock and period status (rev 1.0)
module clk_divider_frac_prog
  import clkgen_pkg::*;
#(
  parameter int INT_W   = CLKGEN_INT_W,
  parameter int FRAC_W  = CLKGEN_FRAC_W,
  parameter int DEF_INT = 8,
  parameter int DEF_NUM = 3,
  parameter int DEF_DEN = 5
) (
  input wire logic               clk,
  input wire logic               rstn,
  clk_divider_frac_prog_if.slave bus
);

  typedef struct packed {
    logic [INT_W-1:0]  m;
    logic [FRAC_W-1:0] num;
    logic [FRAC_W-1:0] den;
  } dcfg_t;

  localparam dcfg_t          c_DEF_CFG = '{m: INT_W'(DEF_INT), num: FRAC_W'(DEF_NUM), den: FRAC_W'(DEF_DEN)};
  localparam logic [INT_W:0] c_ONE     = (INT_W+1)'(1);

  state_t         r_state, w_state_nx;
  dcfg_t          r_act, w_act_nx, r_pend, w_pend_nx, w_use, w_new;
  logic           r_pend_vld, w_pend_vld_nx;
  logic [INT_W:0] r_cnt, w_cnt_nx, r_len, w_len_nx, w_len;
  logic           r_err, w_err_nx;
  logic           r_pulse, w_pulse_nx;
  logic           r_clkdiv, w_clkdiv_nx;
  logic           r_long, w_long_nx;
  logic           r_active, w_active_nx;
  logic           w_cfg_ok, w_accept, w_boundary, w_apply, w_restart, w_flush, w_long;

  assign w_new      = '{m: bus.cfg_int, num: bus.cfg_num, den: bus.cfg_den};
  assign w_cfg_ok   = (bus.cfg_int >= INT_W'(MIN_INT)) && (bus.cfg_den != '0) &&
                      (bus.cfg_num < bus.cfg_den);
  assign w_accept   = bus.cfg_load && w_cfg_ok;
  assign w_boundary = bus.en && ((r_state == ST_IDLE) || (r_cnt == '0));
  assign w_apply    = w_boundary && r_pend_vld;
  assign w_restart  = w_boundary && ((r_state == ST_IDLE) || r_pend_vld);
  assign w_flush    = !bus.en;
  assign w_use      = r_pend_vld ? r_pend : r_act;
  // M+1 computed one bit wider so M = 2^INT_W-1 still works
  assign w_len      = {1'b0, w_use.m} + {{INT_W{1'b0}}, w_long};

  frac_err_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk       (clk),
    .rstn      (rstn),
    .i_flush   (w_flush),
    .i_step    (w_boundary),
    .i_restart (w_restart),
    .i_num     (w_use.num),
    .i_den     (w_use.den),
    .o_long    (w_long)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_act_nx      = r_act;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    w_cnt_nx      = r_cnt;
    w_len_nx      = r_len;
    w_err_nx      = bus.cfg_load && !w_cfg_ok;
    w_pulse_nx    = 1'b0;
    w_clkdiv_nx   = 1'b0;
    w_long_nx     = 1'b0;
    w_active_nx   = 1'b0;

    // Pending is consumed before a same-edge accepted load replaces it
    if (w_apply) begin
      w_act_nx      = r_pend;
      w_pend_vld_nx = 1'b0;
    end
    if (w_accept) begin
      w_pend_nx     = w_new;
      w_pend_vld_nx = 1'b1;
    end

    if (!bus.en) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else if (w_boundary) begin
      w_state_nx  = ST_RUN;
      w_len_nx    = w_len;
      w_cnt_nx    = w_len - c_ONE;
      w_pulse_nx  = (w_cnt_nx == '0);
      w_clkdiv_nx = (w_cnt_nx >= (w_len >> 1));
      w_long_nx   = w_long;
      w_active_nx = 1'b1;
    end else begin
      w_cnt_nx    = r_cnt - c_ONE;
      w_pulse_nx  = (w_cnt_nx == '0);
      w_clkdiv_nx = (w_cnt_nx >= (r_len >> 1));
      w_long_nx   = r_long;
      w_active_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_act      <= c_DEF_CFG;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_pulse    <= 1'b0;
      r_clkdiv   <= 1'b0;
      r_long     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_act      <= w_act_nx;
      r_pend     <= w_pend_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_cnt      <= w_cnt_nx;
      r_len      <= w_len_nx;
      r_err      <= w_err_nx;
      r_pulse    <= w_pulse_nx;
      r_clkdiv   <= w_clkdiv_nx;
      r_long     <= w_long_nx;
      r_active   <= w_active_nx;
    end
  end

  assign bus.cfg_err       = r_err;
  assign bus.clk_div_pulse = r_pulse;
  assign bus.clk_div       = r_clkdiv;
  assign bus.period_long   = r_long;
  assign bus.active        = r_active;

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_frac_prog.sv
`default_nettype none
// tb_clk_divider_frac_prog: directed plus randomized checks against a period-level reference model (rev 1.0)
module tb_clk_divider_frac_prog;
  import clkgen_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;

  clk_divider_frac_prog_if #(.INT_W(8), .FRAC_W(8)) bus ();

  clk_divider_frac_prog #(
    .INT_W(8), .FRAC_W(8), .DEF_INT(8), .DEF_NUM(3), .DEF_DEN(5)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: period k after a restart is long iff floor((k+1)N/D) > floor(kN/D)
  cfg_t a_cfg, p_cfg;
  bit   pv, running;
  int   k, pos, len;
  bit   e_err, e_pulse, e_cd, e_long, e_act;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    a_cfg = '{m: 8'd8, num: 8'd3, den: 8'd5};
    p_cfg = '0;
    pv = 0; running = 0; k = 0; pos = 0; len = 0;
    e_err = 0; e_pulse = 0; e_cd = 0; e_long = 0; e_act = 0;
  endtask

  task automatic model_edge(input bit en_i, input bit ld, input int mi, input int ni, input int di);
    bit ok;
    int m, n, d;
    ok    = (mi >= 2) && (di != 0) && (ni < di);
    e_err = ld && !ok;
    if (!en_i) begin
      running = 0;
      e_pulse = 0; e_cd = 0; e_long = 0; e_act = 0;
    end else begin
      if (!running || pos == len - 1) begin
        if (pv) begin
          a_cfg = p_cfg; pv = 0; k = 0;
        end else if (!running) begin
          k = 0;
        end else begin
          k = (k + 1) % int'(a_cfg.den);
        end
        m = int'(a_cfg.m); n = int'(a_cfg.num); d = int'(a_cfg.den);
        e_long  = (((k * n) % d) + n) >= d;
        len     = m + int'(e_long);
        pos     = 0;
        running = 1;
      end else begin
        pos++;
      end
      e_pulse = (pos == len - 1);
      e_cd    = (pos < (len + 1) / 2);
      e_act   = 1;
    end
    if (ld && ok) begin
      p_cfg = '{m: mi[7:0], num: ni[7:0], den: di[7:0]};
      pv    = 1;
    end
  endtask

  task automatic check_all();
    check_eq("cfg_err",       bus.cfg_err,       e_err);
    check_eq("clk_div_pulse", bus.clk_div_pulse, e_pulse);
    check_eq("clk_div",       bus.clk_div,       e_cd);
    check_eq("period_long",   bus.period_long,   e_long);
    check_eq("active",        bus.active,        e_act);
  endtask

  task automatic step(input bit en_i, input bit ld, input int mi, input int ni, input int di);
    bus.en       = en_i;
    bus.cfg_load = ld;
    bus.cfg_int  = mi[7:0];
    bus.cfg_num  = ni[7:0];
    bus.cfg_den  = di[7:0];
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_edge(en_i, ld, mi, ni, di);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // Default 8+3/5 from idle: lengths 8,9,8,9,9, 43 cycles in total
  task automatic t_default_seq(input string tag);
    int exp_l[5] = '{8, 9, 8, 9, 9};
    int cnt = 0, idx = 0, hi = 0, tot = 0;
    for (int i = 0; i < 60 && idx < 5; i++) begin
      step(1, 0, 0, 0, 0);
      cnt++; tot++;
      if (bus.clk_div) hi++;
      if (bus.clk_div_pulse) begin
        check_eq({tag, "_len"}, cnt, exp_l[idx]);
        check_eq({tag, "_hi"},  hi,  (exp_l[idx] + 1) / 2);
        cnt = 0; hi = 0; idx++;
      end
    end
    check_eq({tag, "_npulse"}, idx, 5);
    check_eq({tag, "_total"},  tot, 43);
  endtask

  initial begin
    rstn = 1'b0;
    bus.en = 0; bus.cfg_load = 0; bus.cfg_int = '0; bus.cfg_num = '0; bus.cfg_den = '0;
    model_reset();
    #3;
    check_all();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    rstn = 1'b1;

    t_default_seq("t1");

    run(3);
    step(1, 1, 4, 0, 1);
    run(40);

    step(1, 1, 3, 1, 0); check_eq("t3_err_den0", bus.cfg_err, 1); run(2);
    step(1, 1, 1, 0, 1); check_eq("t3_err_m1",   bus.cfg_err, 1); run(2);
    step(1, 1, 5, 5, 5); check_eq("t3_err_num",  bus.cfg_err, 1); run(5);

    step(1, 1, 2, 1, 2);
    run(30);

    step(1, 1, 7, 3, 4);
    run(12);
    step(0, 0, 0, 0, 0); check_eq("t5_idle_act", bus.active, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); check_eq("t5_first_short", bus.period_long, 0);
    run(30);

    step(1, 1, 255, 1, 3);
    run(800);

    step(1, 1, 6, 2, 7);
    run(5);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rstn = 1'b1;
    t_default_seq("t6");

    for (int i = 0; i < 1500; i++) begin
      bit en_r, ld_r;
      int mi, ni, di;
      en_r = ($urandom_range(0, 39) != 0);
      ld_r = ($urandom_range(0, 14) == 0);
      mi   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      ni   = int'($urandom_range(0, 9));
      di   = int'($urandom_range(0, 9));
      step(en_r, ld_r, mi, ni, di);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
